// File: rtl/onchip_mem_arb_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;

  localparam int DEF_ADDR_W       = 15;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_BE_W         = DEF_DATA_W / 8;
  localparam int DEF_READ_LATENCY = 1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // One slot of the read-tracking pipeline: is a read in flight, and whose is it.
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_entry_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant records the most recently accepted master.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       last_grant
);

  // A tie goes to whichever master was not served last; no grants while in reset.
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req == 2'b11) begin
        gnt = (last_grant == M1) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= M1;
    end else if (accept) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/onchip_mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM masters.
module onchip_mem_rr_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BE_W         = DEF_BE_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       last_grant;
  logic       sel;
  logic       wr_sel;
  logic       rd_accept;
  rd_entry_t  rsp;
  rd_entry_t [READ_LATENCY-1:0] pipe;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .accept     (ram_chipselect),
    .gnt        (gnt),
    .last_grant (last_grant)
  );

  assign sel            = gnt[1];
  assign m0_waitrequest = ~gnt[0];
  assign m1_waitrequest = ~gnt[1];

  // Read+write from one master is a write; the read half is silently dropped.
  assign wr_sel         = (sel == M1) ? m1_write : m0_write;
  assign ram_chipselect = |gnt;
  assign ram_write      = ram_chipselect & wr_sel;
  assign rd_accept      = ram_chipselect & ~wr_sel;
  assign ram_address    = (sel == M1) ? m1_address    : m0_address;
  assign ram_byteenable = (sel == M1) ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = (sel == M1) ? m1_writedata  : m0_writedata;
  assign ram_clken      = 1'b1;

  // Read tracking: the tail entry lines up with ram_readdata for that read.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= rd_entry_t'{valid: rd_accept, owner: sel};
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign rsp              = pipe[READ_LATENCY-1];
  assign m0_readdatavalid = ~reset & rsp.valid & (rsp.owner == M0);
  assign m1_readdatavalid = ~reset & rsp.valid & (rsp.owner == M1);
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

  a_m0_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
  a_m1_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

  logic unused_ok;
  assign unused_ok = last_grant;

endmodule
